// File: rtl/sender_arbiter_if.sv
// Bundle between the per-channel sender controllers, the arbiter and the shared serializer port.
// The master side is the arbiter; the slave side is the channels plus the serializer.
interface sender_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
);
  localparam int GRANT_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        reqValid;
  logic [NUM_REQ*DATA_W-1:0] reqData;
  logic [NUM_REQ-1:0]        reqAck;
  logic [GRANT_W-1:0]        grantId;
  logic                      busy;
  logic                      Transmit;
  logic                      Ready;
  logic [DATA_W-1:0]         sdrDataIn;
  logic                      txError;

  modport master (
    input  reqValid, reqData, Ready,
    output reqAck, grantId, busy, Transmit, sdrDataIn, txError
  );

  modport slave (
    output reqValid, reqData, Ready,
    input  reqAck, grantId, busy, Transmit, sdrDataIn, txError
  );
endinterface

// File: rtl/sender_arbiter.sv
// Round-robin arbiter sharing one serializer among NUM_REQ channels; grant one cycle after request,
// Transmit for TX_PULSE cycles, then waits for Ready (ack) or TIMEOUT cycles (error pulse, word dropped).
module sender_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 16,
  parameter int TX_PULSE = 3,
  parameter int TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            Reset_n,
  sender_arbiter_if.master bus
);
  localparam int GRANT_W = $clog2(NUM_REQ);
  localparam int CNT_W   = $clog2(TIMEOUT + 1);
  localparam int PCNT_W  = (TX_PULSE > 1) ? $clog2(TX_PULSE) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PULSE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  logic [2:0]         state;
  logic [GRANT_W-1:0] last_grant;
  logic [PCNT_W-1:0]  pulse_cnt;
  logic [CNT_W-1:0]   wait_cnt;

  logic [NUM_REQ-1:0] rot;
  logic [GRANT_W-1:0] win;
  logic [DATA_W-1:0]  win_data;
  int                 first;
  int                 pos;

  // rot[j] is the request of channel (last_grant+1+j) mod NUM_REQ, so the lowest set bit wins.
  always_comb begin
    rot   = NUM_REQ'({2{bus.reqValid}} >> (int'(last_grant) + 1));
    first = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) first = j;
    end
    pos = int'(last_grant) + 1 + first;
    if (pos >= NUM_REQ) pos = pos - NUM_REQ;
    win      = GRANT_W'(pos);
    win_data = bus.reqData[pos*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= S_IDLE;
      last_grant    <= GRANT_W'(NUM_REQ - 1);
      pulse_cnt     <= '0;
      wait_cnt      <= '0;
      bus.reqAck    <= '0;
      bus.grantId   <= '0;
      bus.busy      <= 1'b0;
      bus.Transmit  <= 1'b0;
      bus.sdrDataIn <= '0;
      bus.txError   <= 1'b0;
    end else begin
      bus.reqAck  <= '0;
      bus.txError <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bus.reqValid) begin
            bus.grantId   <= win;
            bus.sdrDataIn <= win_data;
            bus.Transmit  <= 1'b1;
            bus.busy      <= 1'b1;
            pulse_cnt     <= '0;
            state         <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (pulse_cnt == PCNT_W'(TX_PULSE - 1)) begin
            bus.Transmit <= 1'b0;
            wait_cnt     <= '0;
            state        <= S_WAIT;
          end else begin
            pulse_cnt <= pulse_cnt + PCNT_W'(1);
          end
        end
        S_WAIT: begin
          if (bus.Ready) begin
            bus.reqAck <= {{(NUM_REQ-1){1'b0}}, 1'b1} << bus.grantId;
            state      <= S_DONE;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            bus.txError <= 1'b1;
            state       <= S_ABORT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        // A failed channel also moves to the back of the queue.
        S_DONE, S_ABORT: begin
          last_grant <= bus.grantId;
          bus.busy   <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          bus.Transmit <= 1'b0;
          bus.busy     <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sender_arbiter.sv
// Directed bench for sender_arbiter: reset, single grant, round-robin order, timeout,
// data freeze after grant and reset during the Transmit pulse.
module tb_sender_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  sender_arbiter_if #(.NUM_REQ(4), .DATA_W(16)) bus ();

  sender_arbiter #(.NUM_REQ(4), .DATA_W(16), .TX_PULSE(3), .TIMEOUT(255)) dut (
    .clk     (clk),
    .Reset_n (reset_n),
    .bus     (bus.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in IDLE with the channel pending; returns in IDLE after the ack cycle.
  task automatic serve(input int id, input logic [15:0] data, input int ready_cycle);
    tick();
    check("grant_id", 32'(bus.grantId), 32'(id));
    check("grant_data", 32'(bus.sdrDataIn), 32'(data));
    check("tx_c1", 32'(bus.Transmit), 32'd1);
    check("busy_pulse", 32'(bus.busy), 32'd1);
    tick();
    check("tx_c2", 32'(bus.Transmit), 32'd1);
    tick();
    check("tx_c3", 32'(bus.Transmit), 32'd1);
    tick();
    check("tx_off", 32'(bus.Transmit), 32'd0);
    check("no_early_ack", 32'(bus.reqAck), 32'd0);
    repeat (ready_cycle - 1) tick();
    bus.Ready = 1'b1;
    tick();
    bus.Ready = 1'b0;
    check("ack", 32'(bus.reqAck), 32'd1 << id);
    bus.reqValid[id] = 1'b0;
    tick();
    check("ack_once", 32'(bus.reqAck), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int errs;
    bus.reqValid = '0;
    bus.reqData  = '0;
    bus.Ready    = 1'b0;

    // 1. reset state
    tick();
    tick();
    check("rst_ack", 32'(bus.reqAck), 32'd0);
    check("rst_grant", 32'(bus.grantId), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_tx", 32'(bus.Transmit), 32'd0);
    check("rst_data", 32'(bus.sdrDataIn), 32'd0);
    check("rst_err", 32'(bus.txError), 32'd0);
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    check("idle_tx", 32'(bus.Transmit), 32'd0);
    check("idle_busy0", 32'(bus.busy), 32'd0);

    // 2. single request, Ready on the second wait cycle
    bus.reqData[15:0] = 16'hA5A5;
    bus.reqValid = 4'b0001;
    serve(0, 16'hA5A5, 2);

    // 3. all four request after a fresh reset; ch0 re-requests right after its ack
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.reqData = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    bus.reqValid = 4'b1111;
    serve(0, 16'h1111, 1);
    bus.reqData[15:0] = 16'h0F0F;
    bus.reqValid[0] = 1'b1;
    serve(1, 16'h2222, 1);
    serve(2, 16'h3333, 1);
    serve(3, 16'h4444, 1);
    serve(0, 16'h0F0F, 1);

    // 4. timeout on ch2 with ch3 also pending
    bus.reqData[47:32] = 16'hCCCC;
    bus.reqData[63:48] = 16'hDDDD;
    bus.reqValid = 4'b1100;
    tick();
    check("to_grant", 32'(bus.grantId), 32'd2);
    tick();
    tick();
    tick();
    check("to_wait_tx", 32'(bus.Transmit), 32'd0);
    errs = 0;
    repeat (254) begin
      tick();
      if (bus.txError !== 1'b0 || bus.reqAck !== 4'b0 || bus.busy !== 1'b1) errs++;
    end
    check("to_quiet", 32'(errs), 32'd0);
    tick();
    check("to_err", 32'(bus.txError), 32'd1);
    check("to_noack", 32'(bus.reqAck), 32'd0);
    tick();
    check("to_err_pulse", 32'(bus.txError), 32'd0);
    check("to_idle", 32'(bus.busy), 32'd0);
    serve(3, 16'hDDDD, 1);
    serve(2, 16'hCCCC, 2);

    // 6. reqData change after grant is ignored
    bus.reqData[31:16] = 16'h1234;
    bus.reqValid = 4'b0010;
    tick();
    check("dc_grant", 32'(bus.grantId), 32'd1);
    check("dc_data", 32'(bus.sdrDataIn), 32'h1234);
    tick();
    tick();
    tick();
    bus.reqData[31:16] = 16'hFFFF;
    tick();
    check("dc_hold_wait", 32'(bus.sdrDataIn), 32'h1234);
    bus.Ready = 1'b1;
    tick();
    bus.Ready = 1'b0;
    check("dc_ack", 32'(bus.reqAck), 32'b0010);
    check("dc_hold_done", 32'(bus.sdrDataIn), 32'h1234);
    bus.reqValid = 4'b0000;
    tick();
    check("dc_hold_idle", 32'(bus.sdrDataIn), 32'h1234);

    // 5. reset in the second Transmit cycle, then ch0 beats ch3
    bus.reqData[15:0] = 16'h5A5A;
    bus.reqValid = 4'b1001;
    tick();
    check("rp_grant", 32'(bus.grantId), 32'd3);
    check("rp_tx1", 32'(bus.Transmit), 32'd1);
    tick();
    check("rp_tx2", 32'(bus.Transmit), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rp_tx_drop", 32'(bus.Transmit), 32'd0);
    check("rp_busy", 32'(bus.busy), 32'd0);
    tick();
    check("rp_noack", 32'(bus.reqAck), 32'd0);
    check("rp_noerr", 32'(bus.txError), 32'd0);
    reset_n = 1'b1;
    serve(0, 16'h5A5A, 1);
    bus.reqValid = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
